// File: rtl/ice_host_initiator.sv
// Host-side ICE command initiator: frames a command out over the UART,
// then parses ACK/NAK replies, skipping async messages and stale responses.
module ice_host_initiator #(
  parameter int unsigned TIMEOUT_CYC = 32'd2000000,
  parameter int unsigned TX_HOLDOFF  = 32'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_type,
  input  logic [7:0] cmd_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] tx_char,
  output logic       tx_char_valid,
  input  logic       tx_char_ready,
  input  logic [7:0] rx_char,
  input  logic       rx_char_valid,
  output logic       rsp_valid,
  output logic       rsp_ack,
  output logic       rsp_timeout,
  output logic [7:0] rsp_len,
  output logic [7:0] rsp_data,
  output logic       rsp_data_valid,
  output logic       stale_rsp,
  output logic [7:0] evt_id
);

  typedef enum logic [3:0] {
    IDLE, TX_TYPE, TX_EID, TX_LEN, TX_PL,
    RX_TYPE, RX_EID, RX_LEN, RX_PL,
    SKIP_EID, SKIP_LEN, SKIP_PL
  } state_t;

  state_t      state_r, state_s;
  logic        cmd_ready_r;
  logic [7:0]  cmd_type_r, cmd_len_r;
  logic [7:0]  cnt_r, cnt_s;
  logic        nak_r, nak_s;
  logic [7:0]  holdoff_r;
  logic [31:0] timer_r;
  logic [7:0]  evt_id_r;
  logic [7:0]  tx_char_r, tx_byte_s;
  logic        tx_char_valid_r, issue_s;
  logic        rsp_valid_r, rsp_ack_r, rsp_timeout_r;
  logic        done_s, rsp_ack_s, rsp_timeout_s;
  logic [7:0]  rsp_len_r, rsp_len_s;
  logic [7:0]  rsp_data_r, rsp_data_s;
  logic        rsp_data_valid_r, rsp_data_valid_s;
  logic        stale_r, stale_s;
  logic        tx_ok_s, in_rx_s, in_rx_next_s, timeout_s, rx_entry_s;

  assign tx_ok_s      = tx_char_ready && (holdoff_r == 8'd0);
  assign in_rx_s      = state_r inside {RX_TYPE, RX_EID, RX_LEN, RX_PL, SKIP_EID, SKIP_LEN, SKIP_PL};
  assign in_rx_next_s = state_s inside {RX_TYPE, RX_EID, RX_LEN, RX_PL, SKIP_EID, SKIP_LEN, SKIP_PL};
  assign rx_entry_s   = (state_s == RX_TYPE) && (state_r != RX_TYPE);
  // A byte arriving in the same cycle as expiry takes precedence over the timeout.
  assign timeout_s    = in_rx_s && !rx_char_valid && (timer_r == (TIMEOUT_CYC - 32'd1));

  // Next-state and next-output decode
  always_comb begin
    state_s          = state_r;
    cnt_s            = cnt_r;
    nak_s            = nak_r;
    issue_s          = 1'b0;
    tx_byte_s        = tx_char_r;
    done_s           = 1'b0;
    rsp_ack_s        = 1'b0;
    rsp_timeout_s    = 1'b0;
    rsp_len_s        = rsp_len_r;
    rsp_data_s       = rsp_data_r;
    rsp_data_valid_s = 1'b0;
    stale_s          = 1'b0;
    case (state_r)
      IDLE: if (cmd_valid && cmd_ready_r) state_s = TX_TYPE; else state_s = IDLE;
      TX_TYPE: begin
        if (tx_ok_s) begin issue_s = 1'b1; tx_byte_s = cmd_type_r; state_s = TX_EID; end
        else state_s = TX_TYPE;
      end
      TX_EID: begin
        if (tx_ok_s) begin issue_s = 1'b1; tx_byte_s = evt_id_r; state_s = TX_LEN; end
        else state_s = TX_EID;
      end
      TX_LEN: begin
        if (tx_ok_s) begin
          issue_s   = 1'b1;
          tx_byte_s = cmd_len_r;
          cnt_s     = cmd_len_r;
          if (cmd_len_r == 8'd0) state_s = RX_TYPE; else state_s = TX_PL;
        end else state_s = TX_LEN;
      end
      TX_PL: begin
        if (tx_ok_s && pl_valid) begin
          issue_s   = 1'b1;
          tx_byte_s = pl_data;
          cnt_s     = cnt_r - 8'd1;
          if (cnt_r == 8'd1) state_s = RX_TYPE; else state_s = TX_PL;
        end else state_s = TX_PL;
      end
      RX_TYPE: begin
        if (rx_char_valid) begin
          if (rx_char == 8'h00 || rx_char == 8'h01) begin
            nak_s   = rx_char[0];
            state_s = RX_EID;
          end else state_s = SKIP_EID;
        end else state_s = RX_TYPE;
      end
      RX_EID: begin
        if (rx_char_valid) begin
          if (rx_char == evt_id_r) state_s = RX_LEN;
          else begin stale_s = 1'b1; state_s = SKIP_LEN; end
        end else state_s = RX_EID;
      end
      RX_LEN: begin
        if (rx_char_valid) begin
          rsp_len_s = rx_char;
          if (rx_char == 8'd0) begin
            done_s = 1'b1; rsp_ack_s = !nak_r; state_s = IDLE;
          end else begin
            cnt_s = rx_char; state_s = RX_PL;
          end
        end else state_s = RX_LEN;
      end
      RX_PL: begin
        if (rx_char_valid) begin
          rsp_data_s       = rx_char;
          rsp_data_valid_s = 1'b1;
          cnt_s            = cnt_r - 8'd1;
          if (cnt_r == 8'd1) begin
            done_s = 1'b1; rsp_ack_s = !nak_r; state_s = IDLE;
          end else state_s = RX_PL;
        end else state_s = RX_PL;
      end
      SKIP_EID: if (rx_char_valid) state_s = SKIP_LEN; else state_s = SKIP_EID;
      SKIP_LEN: begin
        if (rx_char_valid) begin
          if (rx_char == 8'd0) state_s = RX_TYPE;
          else begin cnt_s = rx_char; state_s = SKIP_PL; end
        end else state_s = SKIP_LEN;
      end
      SKIP_PL: begin
        if (rx_char_valid) begin
          cnt_s = cnt_r - 8'd1;
          if (cnt_r == 8'd1) state_s = RX_TYPE; else state_s = SKIP_PL;
        end else state_s = SKIP_PL;
      end
      default: state_s = IDLE;
    endcase
    if (timeout_s) begin
      state_s = IDLE; done_s = 1'b1; rsp_timeout_s = 1'b1; rsp_ack_s = 1'b0;
    end else begin
      rsp_timeout_s = 1'b0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      cmd_ready_r      <= 1'b0;
      cmd_type_r       <= 8'd0;
      cmd_len_r        <= 8'd0;
      cnt_r            <= 8'd0;
      nak_r            <= 1'b0;
      holdoff_r        <= 8'd0;
      timer_r          <= 32'd0;
      evt_id_r         <= 8'd0;
      tx_char_r        <= 8'd0;
      tx_char_valid_r  <= 1'b0;
      rsp_valid_r      <= 1'b0;
      rsp_ack_r        <= 1'b0;
      rsp_timeout_r    <= 1'b0;
      rsp_len_r        <= 8'd0;
      rsp_data_r       <= 8'd0;
      rsp_data_valid_r <= 1'b0;
      stale_r          <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == IDLE);
      if (state_r == IDLE && cmd_valid && cmd_ready_r) begin
        cmd_type_r <= cmd_type;
        cmd_len_r  <= cmd_len;
      end
      cnt_r <= cnt_s;
      nak_r <= nak_s;
      if (issue_s) holdoff_r <= 8'(TX_HOLDOFF);
      else if (holdoff_r != 8'd0) holdoff_r <= holdoff_r - 8'd1;
      if (!in_rx_next_s || rx_char_valid || rx_entry_s) timer_r <= 32'd0;
      else timer_r <= timer_r + 32'd1;
      if (done_s) evt_id_r <= evt_id_r + 8'd1;
      tx_char_r        <= tx_byte_s;
      tx_char_valid_r  <= issue_s;
      rsp_valid_r      <= done_s;
      rsp_ack_r        <= rsp_ack_s;
      rsp_timeout_r    <= rsp_timeout_s;
      rsp_len_r        <= rsp_len_s;
      rsp_data_r       <= rsp_data_s;
      rsp_data_valid_r <= rsp_data_valid_s;
      stale_r          <= stale_s;
    end
  end

  assign cmd_ready      = cmd_ready_r;
  assign pl_ready       = (state_r == TX_PL) && tx_ok_s;
  assign tx_char        = tx_char_r;
  assign tx_char_valid  = tx_char_valid_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_ack        = rsp_ack_r;
  assign rsp_timeout    = rsp_timeout_r;
  assign rsp_len        = rsp_len_r;
  assign rsp_data       = rsp_data_r;
  assign rsp_data_valid = rsp_data_valid_r;
  assign stale_rsp      = stale_r;
  assign evt_id         = evt_id_r;

endmodule

// File: doc/ice_host_initiator.md
ICE_HOST_INITIATOR -- requirements
Module: ice_host_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 2000000, meaning response timeout in clk cycles (100 ms at 20 MHz).
REQ-002 SHALL have parameter TX_HOLDOFF, default 2, meaning cycles after a tx_char_valid pulse during which tx_char_ready is ignored.
REQ-003 Reset and clock: reset is asynchronous, active-high; clock is clk.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  async active-high reset.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; transfer when both are high.
REQ-007 cmd_type, cmd_len  input  8, 8  ICE message type and payload byte count.
REQ-008 pl_data, pl_valid / pl_ready  input, input / output  8, 1 / 1  command payload stream.
REQ-009 tx_char, tx_char_valid  output  8, 1  byte to UART transmitter, with a 1-cycle latch pulse.
REQ-010 tx_char_ready  input  1  UART transmitter empty.
REQ-011 rx_char, rx_char_valid  input  8, 1  byte from UART receiver, with a 1-cycle valid pulse.
REQ-012 rsp_valid  output  1  1-cycle pulse signalling that the command has completed.
REQ-013 rsp_ack, rsp_timeout  output  1, 1  outcome flags, valid while rsp_valid is high.
REQ-014 rsp_len  output  8  response payload length; held until the next response.
REQ-015 rsp_data, rsp_data_valid  output  8, 1  response payload stream, 1 pulse per byte.
REQ-016 stale_rsp  output  1  1-cycle pulse on an ACK/NAK whose event id does not match the outstanding one.
REQ-017 evt_id  output  8  event id of the current or last command.

Function
REQ-018 Frame format, both directions: type, event id, length, then length payload bytes. ACK type = 0x00; NAK type = 0x01.
REQ-019 States SHALL be IDLE, TX_TYPE, TX_EID, TX_LEN, TX_PL, RX_TYPE, RX_EID, RX_LEN, RX_PL, SKIP_EID, SKIP_LEN, SKIP_PL.
REQ-020 cmd_ready SHALL be high only in IDLE. On a command transfer: latch cmd_type and cmd_len, then go to TX_TYPE.
REQ-021 A TX byte is issued only when all of the following hold:
- tx_char_ready = 1
- the holdoff counter = 0
On issue: tx_char is registered and tx_char_valid pulses for exactly 1 cycle; the holdoff counter loads TX_HOLDOFF.
REQ-022 Header bytes SHALL be sent in this order: cmd_type, evt_id, cmd_len.
- If cmd_len = 0, go from TX_LEN directly to RX_TYPE.
- Otherwise go to TX_PL.
REQ-023 In TX_PL, pl_ready = tx_char_ready & holdoff==0. A pl transfer issues pl_data on the next cycle. After cmd_len transfers, go to RX_TYPE.
REQ-024 evt_id SHALL increment by 1 (mod 256, so 0xFF wraps to 0x00) on entry to IDLE after a completed or timed-out command.
REQ-025 RX_TYPE, for the first byte received:
- 0x00 or 0x01: record it as ack/nak and go to RX_EID.
- Any other value: asynchronous message, go to SKIP_EID.
REQ-026 RX_EID:
- byte == evt_id: go to RX_LEN.
- byte != evt_id: pulse stale_rsp and go to SKIP_LEN.
REQ-027 RX_LEN: latch the byte into rsp_len.
- If it is 0: pulse rsp_valid, set rsp_ack = (type==0x00), return to IDLE.
- Otherwise go to RX_PL.
REQ-028 RX_PL: each received byte appears on rsp_data with rsp_data_valid on the cycle after rx_char_valid. After the last byte, rsp_valid pulses on the same cycle as the last rsp_data_valid.
REQ-029 SKIP states consume the eid and length bytes, then discard length bytes, then return to RX_TYPE. The response timer keeps running.
REQ-030 Timeout counter (32 bit):
- Cleared on entry to RX_TYPE and on every rx_char_valid.
- Increments in all RX_* and SKIP_* states.
- On reaching TIMEOUT_CYC: rsp_valid = 1, rsp_timeout = 1, rsp_ack = 0, rsp_len unchanged, go to IDLE.
REQ-031 rx_char_valid in IDLE or any TX_* state SHALL be discarded with no output activity.
REQ-032 If a timeout and rx_char_valid occur in the same cycle, the byte wins and the counter is cleared.
REQ-033 pl_valid low in TX_PL SHALL stall indefinitely; there is no timeout on the TX side.

Reset
REQ-034 Reset SHALL asynchronously force the following; any in-flight frame is abandoned:
- state = IDLE
- evt_id = 0x00
- holdoff = 0, timer = 0
- rsp_len = 0, tx_char = 0
- all valid/pulse/flag outputs = 0
- cmd_ready = 1 on the first clk edge after reset deassertion
REQ-035 The block SHALL NOT emit a partial frame after reset deassertion.

Verification
REQ-036 Command type 0x56, len 0, evt 0; host replies 00 00 00 -> TX bytes 56 00 00, each spaced ≥ TX_HOLDOFF+1 cycles; rsp_valid with rsp_ack=1, rsp_len=0; evt_id becomes 1.
REQ-037 Command type 0x6D, len 3, payload 11 22 33; reply 01 01 02 AA BB -> TX 6D 01 03 11 22 33; rsp_data AA then BB; rsp_valid with rsp_ack=0 on the BB cycle.
REQ-038 Async frame 42 07 02 x y, then ACK with the correct eid -> no rsp_data for x or y; ACK completes normally.
REQ-039 ACK with eid 0x05 while 0x02 is outstanding, then a correct ACK -> one stale_rsp pulse; stale payload skipped; the second ACK completes.
REQ-040 No reply, TIMEOUT_CYC=100 -> rsp_timeout pulse exactly 100 cycles after the last TX byte; evt_id increments.
REQ-041 Reset asserted during TX_PL, and evt_id 0xFF wrap -> outputs are at reset values within the same cycle; a new command sends eid 00; completing a command at evt_id FF gives evt_id 00.
